// File: rtl/result_reader_if.sv
// Result-word input and byte-stream output bundle for result_reader.
// Latency: none, this is wiring only.
// Backpressure: in_ready throttles the producer and byte_ready throttles the consumer.
interface result_reader_if #(
  parameter int DEPTH = 4
) ();
  logic                     in_valid;
  logic [31:0]              inp1;
  logic                     in_ready;
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     byte_last;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   level;

  // Producer/consumer side: drives words and byte_ready, observes the rest.
  modport master (
    output in_valid, inp1, byte_ready,
    input  in_ready, byte_valid, byte_data, byte_last, overflow, level
  );

  // Block side.
  modport slave (
    input  in_valid, inp1, byte_ready,
    output in_ready, byte_valid, byte_data, byte_last, overflow, level
  );
endinterface

// File: rtl/result_reader.sv
// Buffers 32-bit results in a DEPTH-entry FIFO and drains each word LSB byte first; RESULT_READER_PARITY_EN adds an XOR check byte.
// Latency: word pushed at edge N shows its first byte after edge N+1; words stream back-to-back with no bubble.
// Backpressure: in_ready = !full (a pop never frees room same cycle); bytes hold while byte_ready is low; pushes while full are dropped and flagged.
module result_reader #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  result_reader_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

`ifdef RESULT_READER_PARITY_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [0:0]    r_state;
  logic [31:0]   r_shift;
  logic [2:0]    r_idx;
  logic          r_ovf;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_send;
  logic          w_last;
  logic          w_accept;
  logic          w_load;
  logic [31:0]   w_head;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_push   = bus.in_valid && !w_full;
  assign w_send   = (r_state == S_SEND);
  assign w_last   = w_send && (r_idx == LAST_IDX);
  assign w_accept = w_send && bus.byte_ready;
  // Load the next word when idle, or in the same edge the final byte is taken.
  assign w_load   = !w_empty && ((r_state == S_IDLE) || (w_accept && w_last));
  assign w_head   = r_mem[r_rptr];

`ifdef RESULT_READER_PARITY_EN
  logic [7:0] r_par;
  logic [7:0] w_head_par;

  assign w_head_par = w_head[7:0] ^ w_head[15:8] ^ w_head[23:16] ^ w_head[31:24];
  assign bus.byte_data = !w_send ? 8'h00 :
                         (r_idx == LAST_IDX) ? r_par : r_shift[7:0];

  // Check byte is captured alongside the word so it needs no later recompute.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_par <= 8'h00;
    end else if (w_load) begin
      r_par <= w_head_par;
    end
  end
`else
  assign bus.byte_data = w_send ? r_shift[7:0] : 8'h00;
`endif

  assign bus.in_ready   = !w_full;
  assign bus.byte_valid = w_send;
  assign bus.byte_last  = w_last;
  assign bus.overflow   = r_ovf;
  assign bus.level      = r_level;

  // FIFO storage write; contents need no reset since pointers and level do.
  always_ff @(posedge clk) begin
    if (reset_n && w_push) begin
      r_mem[r_wptr] <= bus.inp1;
    end
  end

  // Pointers wrap naturally; level tracks push/pop so full and empty are unambiguous.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_load) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_level <= r_level + LW'(w_push) - LW'(w_load);
    end
  end

  // Serialiser FSM: load a word, shift one byte out per accepted beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_shift <= 32'h0;
      r_idx   <= 3'd0;
    end else if (w_load) begin
      r_state <= S_SEND;
      r_shift <= w_head;
      r_idx   <= 3'd0;
    end else if (w_accept) begin
      if (w_last) begin
        r_state <= S_IDLE;
        r_idx   <= 3'd0;
      end else begin
        r_idx   <= r_idx + 3'd1;
      end
      r_shift <= {8'h00, r_shift[31:8]};
    end
  end

  // Sticky overflow: set by any word offered while full, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (bus.in_valid && w_full) begin
      r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: single word, back-to-back, backpressure, fill/overflow, wrap, reset mid-word.
// Accepted bytes are compared against a queue built from the pushed words; key cycles also get hand-computed checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_result_reader;

  localparam int DEPTH = 4;
`ifdef RESULT_READER_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  bit   wrap_done;

  result_reader_if #(.DEPTH(DEPTH)) bus ();

  result_reader #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] w);
    logic [7:0] p;
    p = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(i == NB - 1), w[8*i +: 8]});
    end
    if (NB == 5) exp_q.push_back({1'b1, p});
  endtask

  // Valid/ready producer: holds the word until in_ready is seen at an edge.
  task automatic push_word(input logic [31:0] w);
    bit acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.inp1 = w;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      cyc();
      waited++;
    end
    bus.in_valid = 1'b0;
    chk("push_accepted", {31'b0, acc}, 32'd1);
    if (acc) expect_word(w);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (n < 1000 && !(bus.level == '0 && !bus.byte_valid)) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", {31'b0, (n < 1000)}, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    cyc();
  endtask

  // Every accepted byte must be the next expected one, with the right last flag.
  always @(negedge clk) begin
    if (reset_n && bus.byte_valid && bus.byte_ready) begin
      if (exp_q.size() == 0) begin
        chk("stray_byte_queue", exp_q.size(), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("byte_data", {24'b0, bus.byte_data}, {24'b0, mon_e[7:0]});
        chk("byte_last", {31'b0, bus.byte_last}, {31'b0, mon_e[8]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  sw_bytes [5];
    logic [31:0] fw;
    sw_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    bus.in_valid = 1'b0;
    bus.inp1 = 32'h0;
    bus.byte_ready = 1'b0;
    wrap_done = 1'b0;

    // Reset values
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_byte_valid", {31'b0, bus.byte_valid}, 32'd0);
    chk("rst_byte_data", {24'b0, bus.byte_data}, 32'd0);
    chk("rst_byte_last", {31'b0, bus.byte_last}, 32'd0);
    chk("rst_overflow", {31'b0, bus.overflow}, 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Single word: 0x12345678, first byte one cycle after the push
    bus.byte_ready = 1'b1;
    push_word(32'h12345678);
    @(negedge clk);
    chk("sw_not_yet_valid", {31'b0, bus.byte_valid}, 32'd0);
    chk("sw_level_after_push", 32'(bus.level), 32'd1);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("sw_valid", {31'b0, bus.byte_valid}, 32'd1);
      chk("sw_byte", {24'b0, bus.byte_data}, {24'b0, sw_bytes[i]});
      chk("sw_last", {31'b0, bus.byte_last}, {31'b0, (i == NB - 1)});
    end
    @(negedge clk);
    chk("sw_idle_after", {31'b0, bus.byte_valid}, 32'd0);
    chk("sw_level_end", 32'(bus.level), 32'd0);
    wait_idle();

    // Back-to-back: no idle cycle between the two words
    push_word(32'hAABBCCDD);
    push_word(32'h11223344);
    for (int i = 0; i < 2 * NB; i++) begin
      @(negedge clk);
      chk("b2b_no_bubble", {31'b0, bus.byte_valid}, 32'd1);
    end
    @(negedge clk);
    chk("b2b_idle_after", {31'b0, bus.byte_valid}, 32'd0);
    wait_idle();

    // Backpressure: stall 5 cycles on byte 2 (0xFE) of 0xCAFEF00D
    push_word(32'hCAFEF00D);
    cyc();
    cyc();
    cyc();
    bus.byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", {31'b0, bus.byte_valid}, 32'd1);
      chk("bp_data_held", {24'b0, bus.byte_data}, 32'hFE);
      chk("bp_last_held", {31'b0, bus.byte_last}, 32'd0);
      cyc();
    end
    bus.byte_ready = 1'b1;
    wait_idle();

    // Fill and overflow: one word in the shifter, four in the FIFO, sixth dropped
    bus.byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fw = 32'hC0DE0000 + 32'(i) * 32'h00000101;
      push_word(fw);
    end
    @(negedge clk);
    chk("fill_level_full", 32'(bus.level), 32'd4);
    chk("fill_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    chk("fill_no_overflow_yet", {31'b0, bus.overflow}, 32'd0);
    chk("fill_head_byte", {24'b0, bus.byte_data}, 32'h00);
    cyc();
    bus.in_valid = 1'b1;
    bus.inp1 = 32'hDEADBEEF;
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_set", {31'b0, bus.overflow}, 32'd1);
    chk("ovf_level_unchanged", 32'(bus.level), 32'd4);
    cyc();
    bus.byte_ready = 1'b1;
    wait_idle();
    chk("ovf_sticky", {31'b0, bus.overflow}, 32'd1);

    // Pointer wrap: 20 words with random consumer gaps
    fork
      begin
        for (int i = 1; i <= 20; i++) push_word(32'(i));
        wrap_done = 1'b1;
      end
      begin
        while (!wrap_done) begin
          bus.byte_ready = 1'($urandom_range(0, 1));
          cyc();
        end
        bus.byte_ready = 1'b1;
      end
    join
    wait_idle();
    chk("wrap_level_zero", 32'(bus.level), 32'd0);

    // Reset mid-word: after byte 1 of a word, with 2 words queued
    bus.byte_ready = 1'b0;
    push_word(32'h01234567);
    push_word(32'h89ABCDEF);
    push_word(32'h13579BDF);
    @(negedge clk);
    chk("rmw_level_queued", 32'(bus.level), 32'd2);
    cyc();
    bus.byte_ready = 1'b1;
    cyc();
    cyc();
    reset_n = 1'b0;
    cyc();
    exp_q.delete();
    @(negedge clk);
    chk("rmw_byte_valid", {31'b0, bus.byte_valid}, 32'd0);
    chk("rmw_byte_data", {24'b0, bus.byte_data}, 32'd0);
    chk("rmw_byte_last", {31'b0, bus.byte_last}, 32'd0);
    chk("rmw_overflow", {31'b0, bus.overflow}, 32'd0);
    chk("rmw_level", 32'(bus.level), 32'd0);
    chk("rmw_in_ready", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rmw_no_stale", {31'b0, bus.byte_valid}, 32'd0);
    end
    cyc();
    push_word(32'h0BADF00D);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
